mix_round_sequencer: RTL and testbench
======================================

# mix_round_sequencer

Multi-cycle sequencer for the eight-word 32-bit mixing datapath. It accepts a 256-bit seed over a valid/ready handshake and applies the fixed mixing program one step (one eight-assignment group) per clock instead of the whole program in one edge. It returns the mixed state over a second valid/ready handshake. It sits between a job source and a result sink, and a single instance shares one step unit across all 33 program steps.

## Interface
- ROUNDS, default 1: number of full 33-step program passes per job; legal range 1..15.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- in_valid  input  1  seed present on in_data.
- in_ready  output  1  high only in IDLE.
- in_data  input  256  seed; word i is in_data[32i+31:32i].
- out_valid  output  1  high only in DONE.
- out_ready  input  1  sink accepts the result.
- out_data  output  256  state register, always driven; same word packing as in_data.
- busy  output  1  high in RUN.
- step  output  6  index of the next step to execute, 0..32.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid&&in_ready. That edge loads in_data into o[0..7] and clears step and the round counter.
  - RUN executes program[step] at each edge, then increments step. After step 32, step wraps to 0 and the round counter increments. After the last step of pass ROUNDS, the FSM goes to DONE.
  - DONE -> IDLE on out_valid&&out_ready.
- Step semantics: within a step, indices update in order i=0..7. Each update uses already-updated lower words. Index arithmetic is mod 8. Word arithmetic is mod 2^32, unsigned, and shifts are logical.
  - ADDK: o[i]=o[i]+i.
  - CHAIN: o[i]=o[i]+o[i-1].
  - CROSS: o[i]=o[i]+o[i+1]-o[i+5].
  - XSH: o[i]=o[i]^(o[i+3]<<16).
  - SHM: o[i]=o[i]-(o[i+2]>>17)+(o[i+4]>>12).
  - DIFF: o[i]=o[i]+o[i-1]-o[i-2].
  - MULA: o[i]=o[i]*KA[i]+CA[i], with KA={2,3,5,7,11,13,17,19} and CA={3,5,7,11,13,17,19,23}.
  - MULB: o[i]=o[i]*KB[i]+CB[i], with KB={2,3,3,3,5,13,35,87} and CB={0,1,8,27,64,125,216,343}.
- Program, steps 0..32:
  - steps 0-5: ADDK,CHAIN,ADDK,CHAIN,ADDK,CHAIN.
  - step 6: CROSS.
  - step 7: XSH.
  - step 8: SHM.
  - steps 9-20: DIFF.
  - steps 21-32: MULA on odd steps, MULB on even steps.
- State register is written only on the load edge and on RUN edges. It holds in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE; o[0..7]=0 so out_data=0; step=0; round counter=0.
  - out_valid=0, busy=0, in_ready=1 while and after rst is high.
- Latency: with accept at edge E0, steps execute at E1..E(33*ROUNDS). out_valid rises directly after E(33*ROUNDS).
- out_data shows the post-step state after every RUN edge. It is a valid result only while out_valid=1.
- Backpressure: DONE holds out_valid=1 and keeps out_data stable until out_ready. The cycle after the handshake, in_ready=1.
- in_ready=0 throughout RUN and DONE. A new seed is never accepted in the same cycle as a result handshake. in_valid outside IDLE is ignored.
- in_valid and out_ready are don't-care in any state where they are not consulted.
- rst asserted mid-RUN or in DONE aborts the job immediately. The aborted result is never presented.

## Test plan
- Seed o_i=i, ROUNDS=1:
  - after E1, out_data words = 0,2,4,6,8,10,12,14;
  - after E2, words = 14,16,20,26,34,44,56,70;
  - step=2 after E2.
- Seed all 0xFFFFFFFF -> after E1, words = FFFFFFFF,0,1,2,3,4,5,6 (wrap check); busy=1.
- Latency: ROUNDS=1 -> out_valid first high 33 cycles after accept. ROUNDS=2 -> 66 cycles, and step reads 0 after E33 before the second pass.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data constant, out_valid=1, in_ready=0. Pulse out_ready -> IDLE and in_ready=1 next cycle.
- Reset at step 15 -> out_data=0, step=0, busy=0, in_ready=1 asynchronously. A following seed runs the full 33 steps.
- 200 random seeds, back-to-back, random out_ready stalls -> every result matches a golden model applying the whole program sequentially; no dropped or duplicated jobs.

Source files
------------

// File: rtl/mix_round_sequencer.sv
// mix_round_sequencer: multi-cycle sequencer for the eight-word 32-bit mixing
// datapath. It accepts a 256-bit seed, applies one program step per clock for
// ROUNDS passes of 33 steps, and then holds the result until the sink accepts it.
module mix_round_sequencer #(
    parameter int unsigned ROUNDS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         busy,
    output logic [5:0]   step
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADDK, OP_CHAIN, OP_CROSS, OP_XSH,
        OP_SHM,  OP_DIFF,  OP_MULA,  OP_MULB
    } op_t;

    localparam logic [5:0] LAST_STEP  = 6'd32;
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t      state, state_nxt;
    op_t         op;
    logic [31:0] o     [8];
    logic [31:0] o_nxt [8];
    logic [3:0]  round;
    logic        last_edge;

    function automatic logic [31:0] ka(input int unsigned i);
        case (i)
            0:       ka = 32'd2;
            1:       ka = 32'd3;
            2:       ka = 32'd5;
            3:       ka = 32'd7;
            4:       ka = 32'd11;
            5:       ka = 32'd13;
            6:       ka = 32'd17;
            default: ka = 32'd19;
        endcase
    endfunction

    function automatic logic [31:0] ca(input int unsigned i);
        case (i)
            0:       ca = 32'd3;
            1:       ca = 32'd5;
            2:       ca = 32'd7;
            3:       ca = 32'd11;
            4:       ca = 32'd13;
            5:       ca = 32'd17;
            6:       ca = 32'd19;
            default: ca = 32'd23;
        endcase
    endfunction

    function automatic logic [31:0] kb(input int unsigned i);
        case (i)
            0:       kb = 32'd2;
            1:       kb = 32'd3;
            2:       kb = 32'd3;
            3:       kb = 32'd3;
            4:       kb = 32'd5;
            5:       kb = 32'd13;
            6:       kb = 32'd35;
            default: kb = 32'd87;
        endcase
    endfunction

    function automatic logic [31:0] cb(input int unsigned i);
        case (i)
            0:       cb = 32'd0;
            1:       cb = 32'd1;
            2:       cb = 32'd8;
            3:       cb = 32'd27;
            4:       cb = 32'd64;
            5:       cb = 32'd125;
            6:       cb = 32'd216;
            default: cb = 32'd343;
        endcase
    endfunction

    // Decode the operation of the step about to execute.
    always_comb begin
        op = OP_ADDK;
        if (step < 6'd6)
            op = step[0] ? OP_CHAIN : OP_ADDK;
        else if (step == 6'd6)
            op = OP_CROSS;
        else if (step == 6'd7)
            op = OP_XSH;
        else if (step == 6'd8)
            op = OP_SHM;
        else if (step <= 6'd20)
            op = OP_DIFF;
        else
            op = step[0] ? OP_MULA : OP_MULB;
    end

    // One program step: words update in place in index order, so later
    // indices observe the already-updated lower words through o_nxt.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++)
            o_nxt[i] = o[i];
        for (int unsigned i = 0; i < 8; i++) begin
            case (op)
                OP_ADDK:  o_nxt[i] = o_nxt[i] + 32'(i);
                OP_CHAIN: o_nxt[i] = o_nxt[i] + o_nxt[3'(i - 1)];
                OP_CROSS: o_nxt[i] = o_nxt[i] + o_nxt[3'(i + 1)] - o_nxt[3'(i + 5)];
                OP_XSH:   o_nxt[i] = o_nxt[i] ^ (o_nxt[3'(i + 3)] << 16);
                OP_SHM:   o_nxt[i] = o_nxt[i] - (o_nxt[3'(i + 2)] >> 17)
                                              + (o_nxt[3'(i + 4)] >> 12);
                OP_DIFF:  o_nxt[i] = o_nxt[i] + o_nxt[3'(i - 1)] - o_nxt[3'(i - 2)];
                OP_MULA:  o_nxt[i] = o_nxt[i] * ka(i) + ca(i);
                OP_MULB:  o_nxt[i] = o_nxt[i] * kb(i) + cb(i);
                default:  o_nxt[i] = o_nxt[i];
            endcase
        end
    end

    assign last_edge = (step == LAST_STEP) && (round == LAST_ROUND);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_edge)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State words, step index and round counter: load on accept, advance in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++)
                o[i] <= '0;
            step  <= '0;
            round <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < 8; i++)
                            o[i] <= in_data[32*i +: 32];
                        step  <= '0;
                        round <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < 8; i++)
                        o[i] <= o_nxt[i];
                    if (step == LAST_STEP) begin
                        step  <= '0;
                        round <= round + 4'd1;
                    end else begin
                        step <= step + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the state words onto the result bus.
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < 8; i++)
            out_data[32*i +: 32] = o[i];
    end

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Self-checking bench for mix_round_sequencer: directed checks plus a
// randomized stream compared against a whole-program reference model.
module tb_mix_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_valid2;
    logic         in_ready, in_ready2;
    logic [255:0] in_data, in_data2;
    logic         out_valid, out_valid2;
    logic         out_ready, out_ready2;
    logic [255:0] out_data, out_data2;
    logic         busy, busy2;
    logic [5:0]   step, step2;

    int n_checks = 0;
    int n_fail   = 0;

    int KA [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int CA [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
    int KB [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
    int CB [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

    mix_round_sequencer #(.ROUNDS(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .step(step)
    );

    mix_round_sequencer #(.ROUNDS(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .step(step2)
    );

    always #5 clk = ~clk;

    // Apply one program step to a packed 256-bit state, word by word in order.
    function automatic logic [255:0] ref_step(input logic [255:0] v, input int s);
        bit [31:0] w [8];
        logic [255:0] r;
        for (int i = 0; i < 8; i++) w[i] = v[32*i +: 32];
        for (int i = 0; i < 8; i++) begin
            if (s <= 5 && s % 2 == 0)      w[i] = w[i] + 32'(i);
            else if (s <= 5)               w[i] = w[i] + w[(i + 7) % 8];
            else if (s == 6)               w[i] = w[i] + w[(i + 1) % 8] - w[(i + 5) % 8];
            else if (s == 7)               w[i] = w[i] ^ (w[(i + 3) % 8] << 16);
            else if (s == 8)               w[i] = w[i] - (w[(i + 2) % 8] >> 17) + (w[(i + 4) % 8] >> 12);
            else if (s <= 20)              w[i] = w[i] + w[(i + 7) % 8] - w[(i + 6) % 8];
            else if (s % 2 == 1)           w[i] = w[i] * 32'(KA[i]) + 32'(CA[i]);
            else                           w[i] = w[i] * 32'(KB[i]) + 32'(CB[i]);
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [255:0] golden(input logic [255:0] seed, input int rounds);
        logic [255:0] v = seed;
        for (int r = 0; r < rounds; r++)
            for (int s = 0; s < 33; s++)
                v = ref_step(v, s);
        return v;
    endfunction

    function automatic logic [255:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic logic [255:0] rand_seed();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a seed to the ROUNDS=1 instance for exactly one edge.
    task automatic accept(input logic [255:0] seed);
        in_valid = 1'b1;
        in_data  = seed;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 500) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] seed, hold, exp;
        int cyc, stall, jobs;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        tick();
        tick();
        check("rst_data", out_data, '0);
        check("rst_step", step, 6'd0);
        check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
        rst = 1'b0;
        tick();
        check("idle_flags", {in_ready, out_valid, busy}, 3'b100);

        // Seed o_i = i.
        seed = pack8(0, 1, 2, 3, 4, 5, 6, 7);
        accept(seed);
        check("load_data", out_data, seed);
        check("run_flags", {in_ready, out_valid, busy}, 3'b001);
        tick();
        check("e1_words", out_data, pack8(0, 2, 4, 6, 8, 10, 12, 14));
        tick();
        check("e2_words", out_data, pack8(14, 16, 20, 26, 34, 44, 56, 70));
        check("e2_step", step, 6'd2);
        wait_valid(cyc);
        check("lat1", 256'(cyc), 256'(31));
        check("res_seq", out_data, golden(seed, 1));
        pop();
        check("after_pop", {in_ready, out_valid, busy}, 3'b100);

        // All-ones seed: ADDK wraps.
        seed = '1;
        accept(seed);
        tick();
        check("wrap_words", out_data, pack8(-1, 0, 1, 2, 3, 4, 5, 6));
        check("wrap_busy", busy, 1'b1);
        wait_valid(cyc);
        check("res_ones", out_data, golden(seed, 1));
        pop();

        // ROUNDS=2 instance: latency and step wrap between passes.
        seed = rand_seed();
        in_valid2 = 1'b1; in_data2 = seed;
        tick();
        in_valid2 = 1'b0;
        for (int k = 0; k < 33; k++) tick();
        check("r2_step_wrap", step2, 6'd0);
        check("r2_busy", {busy2, out_valid2}, 2'b10);
        check("r2_pass1", out_data2, golden(seed, 1));
        cyc = 33;
        while (!out_valid2 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("lat2", 256'(cyc), 256'(66));
        check("res_r2", out_data2, golden(seed, 2));
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("r2_idle", {in_ready2, out_valid2}, 2'b10);

        // Backpressure with in_valid asserted throughout DONE.
        seed = rand_seed();
        accept(seed);
        wait_valid(cyc);
        check("lat_bp", 256'(cyc), 256'(33));
        exp = golden(seed, 1);
        in_valid = 1'b1;
        in_data = rand_seed();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_data", out_data, exp);
            check("bp_flags", {in_ready, out_valid, busy}, 3'b010);
        end
        pop();
        check("no_same_cycle_accept", {in_ready, out_valid, busy}, 3'b100);
        in_valid = 1'b0;
        tick();
        check("stay_idle", {in_ready, busy}, 2'b10);

        // Asynchronous reset at step 15.
        accept(rand_seed());
        for (int k = 0; k < 15; k++) tick();
        check("pre_rst_step", step, 6'd15);
        #2 rst = 1'b1;
        #1;
        check("arst_data", out_data, '0);
        check("arst_step", step, 6'd0);
        check("arst_flags", {in_ready, out_valid, busy}, 3'b100);
        tick();
        rst = 1'b0;
        tick();
        seed = rand_seed();
        accept(seed);
        wait_valid(cyc);
        check("lat_after_rst", 256'(cyc), 256'(33));
        check("res_after_rst", out_data, golden(seed, 1));
        pop();

        // Random back-to-back stream with random result stalls.
        jobs = 0;
        for (int j = 0; j < 200; j++) begin
            seed = rand_seed();
            accept(seed);
            wait_valid(cyc);
            check("rnd_lat", 256'(cyc), 256'(33));
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) tick();
            check("rnd_res", out_data, golden(seed, 1));
            if (out_valid) jobs++;
            pop();
        end
        check("rnd_jobs", 256'(jobs), 256'(200));
        check("rnd_end_idle", {in_ready, out_valid, busy}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
